// File: rtl/cakegame_input_conditioner.sv
// Input conditioning for the cake game: 2-flop synchronisers, per-input debounce
// counters, one-hot filtering of the play buttons and press/start pulse generation.
module cakegame_input_conditioner #(
  parameter int N_BUTTONS       = 7,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] botoes_raw,
  input  logic                 jogar_raw,
  output logic [N_BUTTONS-1:0] botoes,
  output logic                 jogar,
  output logic                 pressed,
  output logic                 multiple
);

  localparam int NCH = N_BUTTONS + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0]       raw_all;
  logic [NCH-1:0]       sync1;
  logic [NCH-1:0]       sync2;
  logic [NCH-1:0]       stable;
  logic [CNT_WIDTH-1:0] cnt [NCH];
  logic [N_BUTTONS-1:0] stable_btn;
  logic [N_BUTTONS-1:0] botoes_d;
  logic                 stable_jogar;
  logic                 jogar_d;

  // True when at most one bit of the vector is set.
  function automatic logic zero_or_onehot(input logic [N_BUTTONS-1:0] v);
    return (v & (v - N_BUTTONS'(1))) == '0;
  endfunction

  // The start button rides along as the top channel so every input is treated alike.
  assign raw_all      = {jogar_raw, botoes_raw};
  assign stable_btn   = stable[N_BUTTONS-1:0];
  assign stable_jogar = stable[N_BUTTONS];

  // Two-flop synchroniser for all raw inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_all;
      sync2 <= sync1;
    end
  end

  // Per-channel debounce: accept a new level only after it persists for the full window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Previous-cycle copies used for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      botoes_d <= '0;
      jogar_d  <= 1'b0;
    end else begin
      botoes_d <= botoes;
      jogar_d  <= stable_jogar;
    end
  end

  // Chords of two or more buttons are suppressed rather than passed to the game.
  always_comb begin
    botoes   = '0;
    multiple = 1'b0;
    if (zero_or_onehot(stable_btn)) begin
      botoes   = stable_btn;
      multiple = 1'b0;
    end else begin
      botoes   = '0;
      multiple = 1'b1;
    end
    pressed = (botoes != '0) && (botoes_d == '0);
    jogar   = stable_jogar && !jogar_d;
  end

endmodule

// File: tb/tb_cakegame_input_conditioner.sv
// Directed bench for cakegame_input_conditioner with a short debounce window (4 cycles).
module tb_cakegame_input_conditioner;

  localparam int NB = 7;

  logic          clock      = 1'b0;
  logic          reset      = 1'b1;
  logic [NB-1:0] botoes_raw = '0;
  logic          jogar_raw  = 1'b0;
  logic [NB-1:0] botoes;
  logic          jogar;
  logic          pressed;
  logic          multiple;

  int passed = 0;
  int total  = 0;
  int pressed_pulses = 0;
  int jogar_pulses   = 0;

  typedef struct {
    logic [NB-1:0] b;
    logic          j;
    int            n;
    logic [NB-1:0] eb;
    logic          ep;
    logic          em;
    logic          ej;
  } vec_t;

  vec_t vecs [30];

  cakegame_input_conditioner #(
    .N_BUTTONS      (NB),
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH      (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .botoes_raw(botoes_raw),
    .jogar_raw (jogar_raw),
    .botoes    (botoes),
    .jogar     (jogar),
    .pressed   (pressed),
    .multiple  (multiple)
  );

  always #5 clock = ~clock;

  // Pulses last one full cycle, so each is seen at exactly one falling edge.
  always @(negedge clock) begin
    if (pressed) pressed_pulses++;
    if (jogar)   jogar_pulses++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [NB-1:0] eb,
                       input logic ep, input logic em, input logic ej);
    total++;
    if ({botoes, pressed, multiple, jogar} === {eb, ep, em, ej}) passed++;
    else $display("FAIL %s: botoes=%b pressed=%b multiple=%b jogar=%b, expected %b %b %b %b",
                  name, botoes, pressed, multiple, jogar, eb, ep, em, ej);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  initial begin
    int p0;
    int j0;

    // Columns: botoes_raw, jogar_raw, edges to run, expected botoes, pressed, multiple, jogar
    vecs[0]  = '{7'b0000100, 1'b0,  5, 7'b0000000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{7'b0000100, 1'b0,  1, 7'b0000100, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{7'b0000100, 1'b0,  1, 7'b0000100, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{7'b0000100, 1'b0, 10, 7'b0000100, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{7'b0000000, 1'b0,  5, 7'b0000100, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{7'b0000000, 1'b0,  1, 7'b0000000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{7'b0000000, 1'b0,  3, 7'b0000000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{7'b0001010, 1'b0,  5, 7'b0000000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{7'b0001010, 1'b0,  1, 7'b0000000, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{7'b0001010, 1'b0,  3, 7'b0000000, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{7'b0000010, 1'b0,  5, 7'b0000000, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{7'b0000010, 1'b0,  1, 7'b0000010, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{7'b0000010, 1'b0,  1, 7'b0000010, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{7'b0000000, 1'b0,  6, 7'b0000000, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{7'b0000000, 1'b1,  5, 7'b0000000, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{7'b0000000, 1'b1,  1, 7'b0000000, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{7'b0000000, 1'b1,  1, 7'b0000000, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{7'b0000000, 1'b1, 40, 7'b0000000, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{7'b0000000, 1'b0,  6, 7'b0000000, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{7'b0000000, 1'b1,  5, 7'b0000000, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{7'b0000000, 1'b1,  1, 7'b0000000, 1'b0, 1'b0, 1'b1};
    vecs[21] = '{7'b0000000, 1'b1,  1, 7'b0000000, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{7'b0000001, 1'b1,  6, 7'b0000001, 1'b1, 1'b0, 1'b0};
    vecs[23] = '{7'b0000001, 1'b1,  3, 7'b0000001, 1'b0, 1'b0, 1'b0};
    vecs[24] = '{7'b0000100, 1'b1,  5, 7'b0000001, 1'b0, 1'b0, 1'b0};
    vecs[25] = '{7'b0000100, 1'b1,  1, 7'b0000100, 1'b0, 1'b0, 1'b0};
    vecs[26] = '{7'b0000100, 1'b1,  1, 7'b0000100, 1'b0, 1'b0, 1'b0};
    vecs[27] = '{7'b0000000, 1'b0,  6, 7'b0000000, 1'b0, 1'b0, 1'b0};
    vecs[28] = '{7'b0000001, 1'b1,  6, 7'b0000001, 1'b1, 1'b0, 1'b1};
    vecs[29] = '{7'b0000001, 1'b1,  1, 7'b0000001, 1'b0, 1'b0, 1'b0};

    // Reset with every raw input high: outputs must stay quiet.
    botoes_raw = 7'b1111111;
    jogar_raw  = 1'b1;
    step(3);
    check("reset_hold", 7'b0000000, 1'b0, 1'b0, 1'b0);
    botoes_raw = '0;
    jogar_raw  = 1'b0;
    reset      = 1'b0;
    #1;
    check("post_reset", 7'b0000000, 1'b0, 1'b0, 1'b0);
    step(2);
    check("idle", 7'b0000000, 1'b0, 1'b0, 1'b0);

    // Press/release, chord, start button, swap and simultaneous events.
    p0 = pressed_pulses;
    j0 = jogar_pulses;
    for (int i = 0; i < 30; i++) begin
      botoes_raw = vecs[i].b;
      jogar_raw  = vecs[i].j;
      step(vecs[i].n);
      check($sformatf("vec%0d", i), vecs[i].eb, vecs[i].ep, vecs[i].em, vecs[i].ej);
    end
    check_int("vec_pressed_pulses", pressed_pulses - p0, 4);
    check_int("vec_jogar_pulses", jogar_pulses - j0, 3);
    botoes_raw = '0;
    jogar_raw  = 1'b0;
    step(6);
    check("vec_release", 7'b0000000, 1'b0, 1'b0, 1'b0);

    // Bounce on bit 0: each level held 2 cycles, then a steady press.
    p0 = pressed_pulses;
    for (int i = 0; i < 4; i++) begin
      botoes_raw = (i % 2 == 0) ? 7'b0000001 : 7'b0000000;
      step(2);
      check($sformatf("bounce%0d", i), 7'b0000000, 1'b0, 1'b0, 1'b0);
    end
    botoes_raw = 7'b0000001;
    step(5);
    check("bounce_wait", 7'b0000000, 1'b0, 1'b0, 1'b0);
    step(1);
    check("bounce_accept", 7'b0000001, 1'b1, 1'b0, 1'b0);
    step(4);
    check("bounce_hold", 7'b0000001, 1'b0, 1'b0, 1'b0);
    check_int("bounce_pulses", pressed_pulses - p0, 1);
    botoes_raw = '0;
    step(6);
    check("bounce_release", 7'b0000000, 1'b0, 1'b0, 1'b0);

    // Toggling every cycle never settles.
    p0 = pressed_pulses;
    for (int i = 0; i < 20; i++) begin
      botoes_raw[5] = ~botoes_raw[5];
      step(1);
    end
    check("toggle", 7'b0000000, 1'b0, 1'b0, 1'b0);
    check_int("toggle_pulses", pressed_pulses - p0, 0);
    botoes_raw = '0;
    step(6);

    // Reset while bit 6 is two counts into its debounce, then keep holding.
    botoes_raw = 7'b1000000;
    step(4);
    reset = 1'b1;
    #1;
    check("mid_reset_assert", 7'b0000000, 1'b0, 1'b0, 1'b0);
    step(2);
    check("mid_reset_hold", 7'b0000000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    p0 = pressed_pulses;
    step(5);
    check("mid_reset_wait", 7'b0000000, 1'b0, 1'b0, 1'b0);
    step(1);
    check("mid_reset_accept", 7'b1000000, 1'b1, 1'b0, 1'b0);
    step(1);
    check("mid_reset_hold_btn", 7'b1000000, 1'b0, 1'b0, 1'b0);
    check_int("mid_reset_pulses", pressed_pulses - p0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
